// File: rtl/arb_pkg.sv
// Shared encodings and grant policy for the instruction/data memory arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        BUSY  = 2'b10
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam int CNT_W = 8;

    // Data port wins unless the last completed transaction was also data.
    function automatic owner_t pick_owner(input logic if_req, input logic dm_req,
                                          input logic last_d);
        owner_t sel;
        if (dm_req && (!if_req || !last_d))
            sel = OWN_D;
        else
            sel = OWN_I;
        return sel;
    endfunction

endpackage

// File: rtl/arb_timer.sv
// Clear/increment watchdog for the BUSY state of the memory arbiter.
module arb_timer
    import arb_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    localparam logic [CNT_W-1:0] TC_PREV = CNT_W'(TIMEOUT - 2);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc)
            count <= count + 1'b1;
    end

    // tc flags the increment that brings the count to TIMEOUT-1.
    assign tc = inc && (count == TC_PREV);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a single-port variable-latency memory between fetch and data ports.
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_done,
    output logic          if_stall,
    input  logic          dm_rd,
    input  logic          dm_wr,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_done,
    output logic          dm_stall,
    output logic          mem_en,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_done,
    output logic          err
);

    state_t state, state_nxt;
    owner_t owner, sel;
    logic   last_d;
    logic   dm_req, illegal, grant, done_any;
    logic   tmr_clr, tmr_inc, tmo;

    assign dm_req   = dm_rd | dm_wr;
    assign illegal  = dm_rd & dm_wr;
    assign done_any = (state == BUSY) && mem_done;
    assign grant    = (state == IDLE) && !err && !illegal && (if_req || dm_req);
    assign sel      = pick_owner(if_req, dm_req, last_d);
    assign tmr_clr  = (state == ISSUE);
    assign tmr_inc  = (state == BUSY) && !mem_done;

    arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk (clk),
        .rst (rst),
        .clr (tmr_clr),
        .inc (tmr_inc),
        .tc  (tmo)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (grant) state_nxt = ISSUE;
            ISSUE:   state_nxt = BUSY;
            BUSY:    if (mem_done || tmo) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Command registers are loaded only on a grant and held through BUSY.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner     <= OWN_I;
            last_d    <= 1'b0;
            err       <= 1'b0;
            mem_en    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_en <= grant;
            if (grant) begin
                owner <= sel;
                if (sel == OWN_D) begin
                    mem_wr    <= dm_wr;
                    mem_addr  <= dm_addr;
                    mem_wdata <= dm_wdata;
                end else begin
                    mem_wr    <= 1'b0;
                    mem_addr  <= if_addr;
                    mem_wdata <= '0;
                end
            end
            if (done_any)
                last_d <= (owner == OWN_D);
            if (((state == IDLE) && illegal) || tmo)
                err <= 1'b1;
        end
    end

    always_comb begin
        if_done  = done_any && (owner == OWN_I);
        dm_done  = done_any && (owner == OWN_D);
        if_rdata = if_done ? mem_rdata : '0;
        dm_rdata = dm_done ? mem_rdata : '0;
        if_stall = if_req & ~if_done;
        dm_stall = dm_req & ~dm_done;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with hand-scripted memory responses (TIMEOUT=4).
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic [15:0] if_rdata;
    logic        if_done;
    logic        if_stall;
    logic        dm_rd;
    logic        dm_wr;
    logic [15:0] dm_addr;
    logic [15:0] dm_wdata;
    logic [15:0] dm_rdata;
    logic        dm_done;
    logic        dm_stall;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_done;
    logic        err;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(16), .DW(16), .TIMEOUT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_done   (if_done),
        .if_stall  (if_stall),
        .dm_rd     (dm_rd),
        .dm_wr     (dm_wr),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_done   (dm_done),
        .dm_stall  (dm_stall),
        .mem_en    (mem_en),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done),
        .err       (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        if_req = 0; if_addr = '0; dm_rd = 0; dm_wr = 0;
        dm_addr = '0; dm_wdata = '0; mem_rdata = '0; mem_done = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        clear_inputs();
        tick();
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        logic [70:0] snap;
        rst = 1;
        clear_inputs();
        tick();
        tick();
        snap = {mem_en, mem_wr, mem_addr, mem_wdata, err, if_done, dm_done,
                if_rdata, dm_rdata, if_stall, dm_stall};
        total++; if (snap !== 71'd0) $display("FAIL reset_outputs got %h exp 0", snap); else passed++;
        rst = 0;
        #1;
        total++; if (mem_en !== 1'b0) $display("FAIL reset_idle_mem_en got %b exp 0", mem_en); else passed++;
    endtask

    task automatic test_single_fetch();
        if_req = 1; if_addr = 16'h0040;
        #1;
        total++; if (if_stall !== 1'b1) $display("FAIL fetch_stall_c0 got %b exp 1", if_stall); else passed++;
        tick();
        total++; if ({mem_en, mem_wr, mem_addr} !== {1'b1, 1'b0, 16'h0040})
            $display("FAIL fetch_cmd_c1 got en=%b wr=%b addr=%h exp en=1 wr=0 addr=0040", mem_en, mem_wr, mem_addr); else passed++;
        total++; if (if_stall !== 1'b1) $display("FAIL fetch_stall_c1 got %b exp 1", if_stall); else passed++;
        tick();
        total++; if ({mem_en, if_done, if_stall} !== 3'b001)
            $display("FAIL fetch_busy_c2 got en/done/stall=%b exp 001", {mem_en, if_done, if_stall}); else passed++;
        tick();
        mem_done = 1; mem_rdata = 16'hA5C3;
        #1;
        total++; if ({if_done, if_rdata} !== {1'b1, 16'hA5C3})
            $display("FAIL fetch_done_c3 got done=%b rdata=%h exp done=1 rdata=a5c3", if_done, if_rdata); else passed++;
        total++; if ({if_stall, dm_done, dm_rdata} !== 18'd0)
            $display("FAIL fetch_other_c3 got stall=%b dm_done=%b dm_rdata=%h exp 0", if_stall, dm_done, dm_rdata); else passed++;
        if_req = 0;
        tick();
        mem_done = 0; mem_rdata = 16'h1234;
        #1;
        total++; if ({if_done, if_rdata, mem_en} !== 18'd0)
            $display("FAIL fetch_after_c4 got done=%b rdata=%h en=%b exp 0", if_done, if_rdata, mem_en); else passed++;
        mem_rdata = '0;
    endtask

    task automatic test_data_write();
        dm_wr = 1; dm_addr = 16'h0100; dm_wdata = 16'hBEEF;
        #1;
        total++; if (dm_stall !== 1'b1) $display("FAIL wr_stall_c0 got %b exp 1", dm_stall); else passed++;
        tick();
        total++; if ({mem_en, mem_wr, mem_addr, mem_wdata} !== {1'b1, 1'b1, 16'h0100, 16'hBEEF})
            $display("FAIL wr_cmd_c1 got en=%b wr=%b addr=%h wdata=%h exp 1 1 0100 beef", mem_en, mem_wr, mem_addr, mem_wdata); else passed++;
        total++; if (if_done !== 1'b0) $display("FAIL wr_if_done_c1 got %b exp 0", if_done); else passed++;
        tick();
        mem_done = 1;
        #1;
        total++; if ({dm_done, if_done, dm_stall} !== 3'b100)
            $display("FAIL wr_done_c2 got dm_done/if_done/stall=%b exp 100", {dm_done, if_done, dm_stall}); else passed++;
        dm_wr = 0;
        tick();
        mem_done = 0;
        #1;
        total++; if ({dm_done, if_done, mem_en} !== 3'b000)
            $display("FAIL wr_after_c3 got %b exp 000", {dm_done, if_done, mem_en}); else passed++;
    endtask

    task automatic test_contention();
        logic exp_d;
        do_reset();
        if_req = 1; if_addr = 16'h0200;
        dm_rd = 1; dm_addr = 16'h0300;
        for (int i = 0; i < 4; i++) begin
            exp_d = (i % 2 == 0);
            tick();
            total++; if ({mem_en, mem_addr} !== {1'b1, exp_d ? 16'h0300 : 16'h0200})
                $display("FAIL cont_issue_%0d got en=%b addr=%h exp en=1 addr=%h", i, mem_en, mem_addr, exp_d ? 16'h0300 : 16'h0200); else passed++;
            tick();
            mem_done = 1; mem_rdata = 16'h1000 + 16'(i);
            #1;
            total++; if ({dm_done, if_done} !== {exp_d, ~exp_d})
                $display("FAIL cont_owner_%0d got dm_done=%b if_done=%b exp dm_done=%b", i, dm_done, if_done, exp_d); else passed++;
            total++; if ({if_rdata, dm_rdata} !== (exp_d ? {16'h0, 16'h1000 + 16'(i)} : {16'h1000 + 16'(i), 16'h0}))
                $display("FAIL cont_rdata_%0d got if=%h dm=%h", i, if_rdata, dm_rdata); else passed++;
            tick();
            mem_done = 0; mem_rdata = '0;
            if (i == 3) begin if_req = 0; dm_rd = 0; end
            #1;
            total++; if (mem_en !== 1'b0) $display("FAIL cont_gap_%0d got %b exp 0", i, mem_en); else passed++;
        end
        tick();
        total++; if (mem_en !== 1'b0) $display("FAIL cont_quiet got %b exp 0", mem_en); else passed++;
    endtask

    task automatic test_illegal();
        do_reset();
        dm_rd = 1; dm_wr = 1; if_req = 1; if_addr = 16'h0040;
        tick();
        total++; if ({err, mem_en} !== 2'b10) $display("FAIL illegal_err got err=%b en=%b exp err=1 en=0", err, mem_en); else passed++;
        dm_rd = 0; dm_wr = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if ({err, mem_en} !== 2'b10)
                $display("FAIL illegal_hold_%0d got err=%b en=%b exp err=1 en=0", i, err, mem_en); else passed++;
        end
        do_reset();
        #1;
        total++; if (err !== 1'b0) $display("FAIL illegal_cleared got %b exp 0", err); else passed++;
    endtask

    task automatic test_timeout();
        do_reset();
        if_req = 1; if_addr = 16'h0010;
        tick();
        total++; if (mem_en !== 1'b1) $display("FAIL tmo_issue got %b exp 1", mem_en); else passed++;
        tick();
        tick();
        tick();
        total++; if ({err, if_done} !== 2'b00) $display("FAIL tmo_busy3 got err/done=%b exp 00", {err, if_done}); else passed++;
        tick();
        total++; if ({err, if_done, mem_en} !== 3'b100)
            $display("FAIL tmo_fire got err/done/en=%b exp 100", {err, if_done, mem_en}); else passed++;
        for (int i = 0; i < 3; i++) begin
            mem_done = (i == 1);
            tick();
            total++; if ({err, if_done, mem_en} !== 3'b100)
                $display("FAIL tmo_hold_%0d got err/done/en=%b exp 100", i, {err, if_done, mem_en}); else passed++;
        end
        mem_done = 0; if_req = 0;
    endtask

    task automatic test_reset_mid_busy();
        do_reset();
        if_req = 1; if_addr = 16'h0020;
        tick();
        tick();
        rst = 1;
        tick();
        rst = 0; if_req = 0;
        tick();
        mem_done = 1; mem_rdata = 16'hFFFF;
        #1;
        total++; if ({if_done, dm_done, err, mem_en, mem_addr, if_rdata, dm_rdata} !== 52'd0)
            $display("FAIL rstmid_stray got done=%b/%b err=%b en=%b addr=%h rdata=%h/%h exp 0",
                     if_done, dm_done, err, mem_en, mem_addr, if_rdata, dm_rdata); else passed++;
        tick();
        mem_done = 0; mem_rdata = '0;
        if_req = 1; if_addr = 16'h0ABC;
        tick();
        total++; if ({mem_en, mem_addr} !== {1'b1, 16'h0ABC})
            $display("FAIL rstmid_regrant got en=%b addr=%h exp en=1 addr=0abc", mem_en, mem_addr); else passed++;
        tick();
        mem_done = 1; mem_rdata = 16'h5A5A;
        #1;
        total++; if ({if_done, if_rdata} !== {1'b1, 16'h5A5A})
            $display("FAIL rstmid_done got done=%b rdata=%h exp done=1 rdata=5a5a", if_done, if_rdata); else passed++;
        if_req = 0;
        tick();
        mem_done = 0; mem_rdata = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1;
        clear_inputs();
        test_reset();
        test_single_fetch();
        test_data_write();
        test_contention();
        test_illegal();
        test_timeout();
        test_reset_mid_busy();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
